// File: rtl/disp_scan_if.sv
// Display scan bus: the data/control inputs the scan controller consumes and the
// decoder/anode drive it produces. The master side feeds data, the slave side is the scanner.
interface disp_scan_if #(
  parameter int N_DIG = 8
);
  logic               en;
  logic               load;
  logic [4*N_DIG-1:0] hex_in;
  logic [N_DIG-1:0]   point_in;
  logic [N_DIG-1:0]   blank_in;
  logic [3:0]         dec_d;
  logic               dec_point;
  logic               dec_le;
  logic [N_DIG-1:0]   an;
  logic               frame_done;

  modport master (
    output en, load, hex_in, point_in, blank_in,
    input  dec_d, dec_point, dec_le, an, frame_done
  );

  modport slave (
    input  en, load, hex_in, point_in, blank_in,
    output dec_d, dec_point, dec_le, an, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-seg display through one shared
// decoder, with double-buffered data. Define DISP_SCAN_LZB_EN for leading-zero blanking.
module disp_scan_ctrl #(
  parameter int N_DIG    = 8,
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 2,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_scan_if.slave bus
);
  localparam int               KW        = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [KW-1:0]    LAST_DIG  = KW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] AN_OFF    = '1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t             state;
  logic [KW-1:0]      dig;
  logic [CNT_W-1:0]   cnt;
  logic [4*N_DIG-1:0] sh_hex, disp_hex;
  logic [N_DIG-1:0]   sh_pt, sh_blank, disp_pt, disp_blank;
  logic               pending;

  logic               advance, wrap, copy;
  logic [KW-1:0]      nxt_dig;
  logic [4*N_DIG-1:0] src_hex;
  logic [N_DIG-1:0]   src_pt, src_blank, nxt_an;
  logic [3:0]         nxt_nib;
  logic               nxt_pt, nxt_le;

  // Next digit to show; at a frame boundary it is taken from the freshly copied shadow.
  always_comb begin
    advance = bus.en && ((state == IDLE) ||
                         (state == SHOW && cnt == SHOW_LAST && GAP_CYC == 0) ||
                         (state == GAP  && cnt == GAP_LAST));
    wrap      = (state == IDLE) || (dig == LAST_DIG);
    nxt_dig   = wrap ? '0 : dig + 1'b1;
    copy      = wrap && pending;
    src_hex   = copy ? sh_hex   : disp_hex;
    src_pt    = copy ? sh_pt    : disp_pt;
    src_blank = copy ? sh_blank : disp_blank;
    nxt_nib   = src_hex[4*int'(nxt_dig) +: 4];
    nxt_pt    = src_pt[nxt_dig];
    nxt_an    = ~(N_DIG'(1) << nxt_dig);
`ifdef DISP_SCAN_LZB_EN
    nxt_le    = src_blank[nxt_dig] |
                ((nxt_dig != '0) && !nxt_pt && ((src_hex >> (4*int'(nxt_dig))) == '0));
`else
    nxt_le    = src_blank[nxt_dig];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dig            <= '0;
      cnt            <= '0;
      sh_hex         <= '0;
      sh_pt          <= '0;
      sh_blank       <= '0;
      disp_hex       <= '0;
      disp_pt        <= '0;
      disp_blank     <= '0;
      pending        <= 1'b0;
      bus.an         <= AN_OFF;
      bus.dec_d      <= 4'd0;
      bus.dec_le     <= 1'b1;
      bus.dec_point  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (!bus.en) begin
        state         <= IDLE;
        dig           <= '0;
        cnt           <= '0;
        bus.an        <= AN_OFF;
        bus.dec_d     <= 4'd0;
        bus.dec_le    <= 1'b1;
        bus.dec_point <= 1'b0;
      end else if (advance) begin
        state          <= SHOW;
        dig            <= nxt_dig;
        cnt            <= '0;
        bus.an         <= nxt_an;
        bus.dec_d      <= nxt_nib;
        bus.dec_point  <= nxt_pt;
        bus.dec_le     <= nxt_le;
        bus.frame_done <= wrap;
        if (copy) begin
          disp_hex   <= sh_hex;
          disp_pt    <= sh_pt;
          disp_blank <= sh_blank;
          pending    <= 1'b0;
        end
      end else begin
        case (state)
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state      <= GAP;
              cnt        <= '0;
              bus.an     <= AN_OFF;
              bus.dec_le <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP:     cnt <= cnt + 1'b1;
          default: cnt <= '0;
        endcase
      end
      // Placed last so a load on a frame-boundary edge keeps pending set for the next frame.
      if (bus.load) begin
        sh_hex   <= bus.hex_in;
        sh_pt    <= bus.point_in;
        sh_blank <= bus.blank_in;
        pending  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a GAP_CYC=1 and a GAP_CYC=0 instance share stimulus and are
// compared each cycle against a time-slot reference model.
module tb_disp_scan_ctrl;
  localparam int N  = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load;
  logic [15:0] hex;
  logic [3:0]  pt, blk;

  disp_scan_if #(.N_DIG(N)) bus_g ();
  disp_scan_if #(.N_DIG(N)) bus_z ();

  assign bus_g.en = en;   assign bus_g.load = load;   assign bus_g.hex_in = hex;
  assign bus_g.point_in = pt;   assign bus_g.blank_in = blk;
  assign bus_z.en = en;   assign bus_z.load = load;   assign bus_z.hex_in = hex;
  assign bus_z.point_in = pt;   assign bus_z.blank_in = blk;

  disp_scan_ctrl #(.N_DIG(N), .SCAN_DIV(SD), .GAP_CYC(1), .CNT_W(8)) u_dut_gap (
    .clk(clk), .rst_n(rst_n), .bus(bus_g));
  disp_scan_ctrl #(.N_DIG(N), .SCAN_DIV(SD), .GAP_CYC(0), .CNT_W(8)) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .bus(bus_z));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state per instance: active flag, cycle index within frame, buffers.
  bit          act [2];
  int          t   [2];
  logic [15:0] mdh [2], msh [2];
  logic [3:0]  mdp [2], mdb [2], msp [2], msb [2];
  bit          mpend [2];

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int period_of(int i);
    return N * (SD + gap_of(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; t[i] = 0; mpend[i] = 0;
      mdh[i] = '0; msh[i] = '0; mdp[i] = '0; mdb[i] = '0; msp[i] = '0; msb[i] = '0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!en) act[i] = 0;
        else begin
          if (!act[i]) begin act[i] = 1; t[i] = 0; end
          else t[i] = (t[i] + 1) % period_of(i);
          if (t[i] == 0 && mpend[i]) begin
            mdh[i] = msh[i]; mdp[i] = msp[i]; mdb[i] = msb[i]; mpend[i] = 0;
          end
        end
        if (load) begin
          msh[i] = hex; msp[i] = pt; msb[i] = blk; mpend[i] = 1;
        end
      end
    end
  endtask

  // Packed as {frame_done, an[3:0], dec_le, dec_point, dec_d[3:0]}.
  function automatic logic [10:0] expect_out(int i);
    int slot, dg, ph;
    logic [3:0] d, a;
    logic p, le, lz;
    if (!act[i]) return {1'b0, 4'hF, 1'b1, 1'b0, 4'h0};
    slot = SD + gap_of(i);
    dg = t[i] / slot;
    ph = t[i] % slot;
    d  = mdh[i][4*dg +: 4];
    p  = mdp[i][dg];
    lz = 1'b0;
`ifdef DISP_SCAN_LZB_EN
    if (dg != 0 && !p && (mdh[i] >> (4*dg)) == 16'h0) lz = 1'b1;
`endif
    if (ph < SD) begin
      a  = ~(4'b0001 << dg);
      le = mdb[i][dg] | lz;
    end else begin
      a  = 4'hF;
      le = 1'b1;
    end
    return {(t[i] == 0), a, le, p, d};
  endfunction

  task automatic check(string tag);
    logic [10:0] obs, exp;
    for (int i = 0; i < 2; i++) begin
      obs = (i == 0) ? {bus_g.frame_done, bus_g.an, bus_g.dec_le, bus_g.dec_point, bus_g.dec_d}
                     : {bus_z.frame_done, bus_z.an, bus_z.dec_le, bus_z.dec_point, bus_z.dec_d};
      exp = expect_out(i);
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s inst%0d t=%0d observed=%h expected=%h", tag, i, t[i], obs, exp);
      end
    end
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(int n, string tag);
    repeat (n) cyc(tag);
  endtask

  task automatic do_load(logic [15:0] h, logic [3:0] p, logic [3:0] b, string tag);
    hex = h; pt = p; blk = b; load = 1'b1;
    cyc(tag);
    load = 1'b0;
  endtask

  initial begin
    logic [10:0] rst_obs;
    en = 1'b0; load = 1'b0; hex = '0; pt = '0; blk = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    run(3, "reset");
    rst_n = 1'b1;
    en = 1'b1;
    run(7, "first_frame");

    // Asynchronous reset between edges, mid-SHOW.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      rst_obs = (i == 0) ? {bus_g.frame_done, bus_g.an, bus_g.dec_le, bus_g.dec_point, bus_g.dec_d}
                         : {bus_z.frame_done, bus_z.an, bus_z.dec_le, bus_z.dec_point, bus_z.dec_d};
      vectors++;
      assert (rst_obs === 11'b0_1111_1_0_0000) else begin
        miscompares++;
        $error("FAIL async_reset inst%0d observed=%h expected=%h", i, rst_obs, 11'b0_1111_1_0_0000);
      end
    end
    en = 1'b0;
    @(negedge clk);
    run(2, "reset_hold");
    rst_n = 1'b1;

    do_load(16'h4A27, 4'b0010, 4'b0000, "load_4a27");
    en = 1'b1;
    run(60, "scan");

    run(7, "pre_dbuf");
    do_load(16'h1234, 4'b0000, 4'b0000, "dbuf");
    run(30, "dbuf_run");

    for (int k = 0; k < 40 && t[0] != period_of(0) - 1; k++) cyc("align");
    vectors++;
    assert (t[0] == period_of(0) - 1) else begin
      miscompares++;
      $error("FAIL align_timeout observed=%0d expected=%0d", t[0], period_of(0) - 1);
    end
    do_load(16'hBEEF, 4'b1000, 4'b0000, "coincide");
    run(45, "coincide_run");

    do_load(16'h4A27, 4'b0010, 4'b0100, "blank");
    run(45, "blank_run");

    for (int k = 0; k < 20 && (t[0] % (SD + 1)) != SD; k++) cyc("find_gap");
    vectors++;
    assert ((t[0] % (SD + 1)) == SD) else begin
      miscompares++;
      $error("FAIL gap_timeout observed=%0d expected=%0d", t[0] % (SD + 1), SD);
    end
    en = 1'b0;
    cyc("en_off");
    run(3, "idle");
    en = 1'b1;
    run(25, "restart");

    do_load(16'h0030, 4'b0000, 4'b0000, "lzb_0030");
    run(45, "lzb_0030_run");
    do_load(16'h0000, 4'b0000, 4'b0000, "lzb_0000");
    run(45, "lzb_0000_run");

    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom & $urandom), "rand_load");
      else
        cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.
- One shared MC14495_ZJU decoder serves all digits. This block drives the decoder's D3..D0, point and LE inputs and the per-digit anode selects.
- It rotates through the digits at a programmable rate, with a blanking gap between digits to prevent ghosting.
- Display data is double-buffered so a load never tears a frame.

Parameters:
- N_DIG, 8: number of digits scanned (1..8).
- SCAN_DIV, 50000: clk cycles each digit is lit (>=1).
- GAP_CYC, 2: clk cycles of all-off dead time after each digit (0 = no gap).
- CNT_W, 16: width of the dwell counter; must hold max(SCAN_DIV, GAP_CYC).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 = display dark.
- load  in  1  single-cycle strobe that captures hex_in, point_in and blank_in into the shadow registers.
- hex_in  in  4*N_DIG  nibble k is the value for digit k (digit 0 = LSB nibble).
- point_in  in  N_DIG  decimal point per digit, 1 = lit.
- blank_in  in  N_DIG  per-digit blank, 1 = digit dark.
- dec_d  out  4  to decoder D3..D0.
- dec_point  out  1  to decoder point.
- dec_le  out  1  to decoder LE; 1 = blank.
- an  out  N_DIG  digit selects, active-low.
- frame_done  out  1  one-cycle pulse at the start of each new frame.

Behaviour:
- Reset values (asynchronous, effective immediately even mid-operation): an = all 1s, dec_d = 0, dec_le = 1, dec_point = 0, frame_done = 0. Internal state: FSM = IDLE, digit index = 0, dwell counter = 0, shadow and display registers = 0, pending = 0.
- All outputs are registered.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - Outputs are held at their reset values.
  - When en=1, on the next edge: go to SHOW with k=0. Copy shadow to display if pending, then clear pending. Pulse frame_done.
- SHOW (digit k):
  - an[k]=0, all other an bits 1.
  - dec_d = display_hex[4k+3:4k]; dec_point = display_pt[k]; dec_le = display_blank[k].
  - Outputs are held for exactly SCAN_DIV cycles.
  - Then go to GAP if GAP_CYC>0. Otherwise go straight to the next digit.
- GAP:
  - an = all 1s, dec_le = 1. dec_d and dec_point hold their previous values.
  - Lasts exactly GAP_CYC cycles, then go to SHOW for the next digit.
- Next digit: k+1, wrapping from N_DIG-1 to 0.
  - The wrap is the frame boundary: do the pending shadow-to-display copy and pulse frame_done in the same cycle SHOW digit 0 is entered.
- Frame period: N_DIG*(SCAN_DIV+GAP_CYC) cycles.
- load:
  - Shadow registers and pending=1 update on the edge where load=1. Accepted in every state.
  - A load in the same cycle as a frame-boundary copy: the copy takes the old shadow contents, the shadow takes the new data, and pending stays 1. The new data appears at the following frame.
  - Back-to-back loads: the last one wins.
- en falling in any state: the next edge goes to IDLE, k=0, outputs return to reset values. Pending is kept.
- Dwell counter: counts 0..limit-1 and is cleared on every state or digit change.

Optional Feature:
- Macro: DISP_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - In SHOW, digit k is also blanked (dec_le=1) when its nibble and every higher-index nibble in the display register are 0 and k != 0.
  - Digit 0 always shows. A lit point_in[k] cancels blanking for that digit.
- Undefined: only blank_in controls dec_le.

Test Plan:
Bench uses N_DIG=4, SCAN_DIV=4, GAP_CYC=1 unless noted.
1. Reset mid-SHOW: assert rst_n=0 -> an=4'b1111, dec_le=1, dec_d=0, frame_done=0 within the same cycle, without waiting for a clock edge. Release, en=1 -> frame_done pulses one cycle and an=4'b1110.
2. Scan sequence: load hex_in=16'h4A27, point_in=4'b0010, en=1.
   - Each frame: an = 1110 (d=7), 1101 (d=2, point=1), 1011 (d=A), 0111 (d=4).
   - Each digit lasts 4 cycles, with one 1111 gap cycle between digits.
   - frame_done period = 20 cycles.
3. Double buffering: load 16'h1234 mid-frame -> outputs keep the old data until the next frame_done, then show 4,3,2,1. Load coinciding with frame_done -> value appears one frame later.
4. Blank and enable: blank_in=4'b0100 -> digit 2 shows dec_le=1 while an=1011. en dropped mid-GAP -> IDLE next cycle, an=1111. en reasserted -> scan restarts at digit 0 with frame_done.
5. GAP_CYC=0 build: no all-off cycles, an moves directly 1110 -> 1101, frame period = 16 cycles.
6. DISP_SCAN_LZB_EN defined: hex 16'h0030 -> digits 3 and 2 have dec_le=1, digits 1 and 0 are lit. hex 16'h0000 -> only digit 0 lit, showing 0. Undefined: all four digits are lit.
